// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point datapath: field widths,
// special encodings, adder FSM states and the operand classifier.
package fp32_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } fsm_state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_NAN
   } op_class_t;

   // Denormals are reported as zero so that they flush to signed zero.
   function automatic op_class_t classify(input logic [31:0] x);
      if (x[30:23] == 8'hFF) begin
         return (x[22:0] != 23'h0) ? CLS_NAN : CLS_INF;
      end
      if (x[30:23] == 8'h00) begin
         return CLS_ZERO;
      end
      return CLS_NORMAL;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the 28-bit adder sum.
// An all-zero input reports 28.
module fp_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (value[i]) begin
            count = 5'(27 - i);
         end
      end
   end

endmodule

// File: rtl/adder.sv
// Multi-cycle binary32 adder with load / result_ready / result_ack handshake.
// Round to nearest even, denormals flushed to zero, NaNs reported as QNAN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for load; operands latched on the accepting edge
//   ST_UNPACK | split fields, classify, resolve special operands
//   ST_ALIGN  | order by magnitude, shift smaller significand (G/R/S kept)
//   ST_ADD    | add or subtract aligned significands
//   ST_NORM   | carry shift right or leading-zero barrel shift left
//   ST_ROUND  | round to nearest even, pack, range check
//   ST_DONE   | Result valid, waiting for result_ack
module adder
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] Number1,
   input  logic [31:0] Number2,
   input  logic        result_ack,
   output logic [31:0] Result,
   output logic        result_ready
);

   fsm_state_t state, state_next;

   logic [31:0]       a_q, b_q;
   logic              sa_q, sb_q;
   logic [EXP_W-1:0]  ea_q, eb_q;
   logic [FRAC_W:0]   ma_q, mb_q;
   logic              special_q;
   logic [31:0]       special_val_q;
   logic              sign_q, sub_q;
   logic [EXP_W-1:0]  exp_q;
   logic [26:0]       ma_al_q, mb_al_q;
   logic [27:0]       sum_q;
   logic [26:0]       nm_q;
   logic signed [9:0] en_q;
   logic              zero_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (load) state_next = ST_UNPACK;
         ST_UNPACK: state_next = ST_ALIGN;
         ST_ALIGN:  state_next = ST_ADD;
         ST_ADD:    state_next = ST_NORM;
         ST_NORM:   state_next = ST_ROUND;
         ST_ROUND:  state_next = ST_DONE;
         ST_DONE:   if (result_ack) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   op_class_t   cls_a, cls_b;
   logic        special_hit;
   logic [31:0] special_val;

   assign cls_a = classify(a_q);
   assign cls_b = classify(b_q);

   // Specials still walk the remaining states so latency stays fixed.
   always_comb begin
      special_hit = 1'b1;
      special_val = 32'h0;
      if (cls_a == CLS_NAN || cls_b == CLS_NAN)        special_val = QNAN;
      else if (cls_a == CLS_INF && cls_b == CLS_INF)   special_val = (a_q[31] != b_q[31]) ? QNAN : a_q;
      else if (cls_a == CLS_INF)                       special_val = a_q;
      else if (cls_b == CLS_INF)                       special_val = b_q;
      else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) special_val = {a_q[31] & b_q[31], 31'h0};
      else if (cls_a == CLS_ZERO)                      special_val = b_q;
      else if (cls_b == CLS_ZERO)                      special_val = a_q;
      else                                             special_hit = 1'b0;
   end

   logic             a_big;
   logic [EXP_W-1:0] e_big, e_small, e_diff;
   logic [FRAC_W:0]  m_big, m_small;
   logic [4:0]       shamt;
   logic [50:0]      wide;
   logic [26:0]      aligned;

   // Shift is capped at 27: beyond that the smaller operand only feeds sticky.
   always_comb begin
      a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
      e_big   = a_big ? ea_q : eb_q;
      e_small = a_big ? eb_q : ea_q;
      m_big   = a_big ? ma_q : mb_q;
      m_small = a_big ? mb_q : ma_q;
      e_diff  = e_big - e_small;
      shamt   = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
      wide    = {m_small, 27'h0} >> shamt;
      aligned = {wide[50:25], |wide[24:0]};
   end

   logic [27:0] sum;
   assign sum = sub_q ? ({1'b0, ma_al_q} - {1'b0, mb_al_q})
                      : ({1'b0, ma_al_q} + {1'b0, mb_al_q});

   logic [4:0]        lz, lz_m1;
   logic [26:0]       nm;
   logic signed [9:0] en;

   fp_lzc u_lzc (
      .value (sum_q),
      .count (lz)
   );

   always_comb begin
      lz_m1 = lz - 5'd1;
      if (sum_q[27]) begin
         nm = {sum_q[27:2], sum_q[1] | sum_q[0]};
         en = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         nm = sum_q[26:0] << lz_m1;
         en = $signed({2'b00, exp_q}) - $signed({5'b00000, lz_m1});
      end
   end

   logic              round_up;
   logic [24:0]       m25;
   logic [22:0]       mant;
   logic signed [9:0] er;
   logic [31:0]       packed_val;

   always_comb begin
      round_up = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
      m25      = {1'b0, nm_q[26:3]} + {24'h0, round_up};
      if (m25[24]) begin
         mant = m25[23:1];
         er   = en_q + 10'sd1;
      end else begin
         mant = m25[22:0];
         er   = en_q;
      end
      if (special_q)           packed_val = special_val_q;
      else if (zero_q)         packed_val = 32'h0;
      else if (er >= 10'sd255) packed_val = {sign_q, 8'hFF, 23'h0};
      else if (er <= 10'sd0)   packed_val = {sign_q, 31'h0};
      else                     packed_val = {sign_q, er[7:0], mant};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q           <= '0;
         b_q           <= '0;
         sa_q          <= 1'b0;
         sb_q          <= 1'b0;
         ea_q          <= '0;
         eb_q          <= '0;
         ma_q          <= '0;
         mb_q          <= '0;
         special_q     <= 1'b0;
         special_val_q <= '0;
         sign_q        <= 1'b0;
         sub_q         <= 1'b0;
         exp_q         <= '0;
         ma_al_q       <= '0;
         mb_al_q       <= '0;
         sum_q         <= '0;
         nm_q          <= '0;
         en_q          <= '0;
         zero_q        <= 1'b0;
         Result        <= '0;
         result_ready  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  a_q <= Number1;
                  b_q <= Number2;
               end
            end
            ST_UNPACK: begin
               sa_q          <= a_q[31];
               sb_q          <= b_q[31];
               ea_q          <= a_q[30:23];
               eb_q          <= b_q[30:23];
               ma_q          <= (cls_a == CLS_NORMAL) ? {1'b1, a_q[22:0]} : '0;
               mb_q          <= (cls_b == CLS_NORMAL) ? {1'b1, b_q[22:0]} : '0;
               special_q     <= special_hit;
               special_val_q <= special_val;
            end
            ST_ALIGN: begin
               sign_q  <= a_big ? sa_q : sb_q;
               sub_q   <= sa_q ^ sb_q;
               exp_q   <= e_big;
               ma_al_q <= {m_big, 3'b000};
               mb_al_q <= aligned;
            end
            ST_ADD: sum_q <= sum;
            ST_NORM: begin
               nm_q   <= nm;
               en_q   <= en;
               zero_q <= (sum_q == 28'h0);
            end
            ST_ROUND: begin
               Result       <= packed_val;
               result_ready <= 1'b1;
            end
            ST_DONE: if (result_ack) result_ready <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the binary32 adder: directed cases plus random
// operands compared against an exact-integer reference model.
module tb_adder;

   logic        clk = 1'b0;
   logic        reset, load, result_ack;
   logic [31:0] Number1, Number2, Result;
   logic        result_ready;

   int checks = 0;
   int errors = 0;

   adder dut (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .Number1      (Number1),
      .Number2      (Number2),
      .result_ack   (result_ack),
      .Result       (Result),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // Exact sum as a scaled integer, then one round-to-nearest-even step.
   function automatic logic [31:0] ref_add(input logic [31:0] x_in, input logic [31:0] y_in);
      logic [31:0] x, y, t;
      int ex, ey, d, p, shift, e;
      longint mx, my, s, m, q, rem, half;
      bit nx, ny, ix, iy, zx, zy, neg;
      x = x_in;
      y = y_in;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      if (nx || ny) return 32'h7FC00000;
      if (ix && iy) return (x[31] != y[31]) ? 32'h7FC00000 : x;
      if (ix) return x;
      if (iy) return y;
      if (zx && zy) return {x[31] & y[31], 31'h0};
      if (zx) return y;
      if (zy) return x;
      if (x[30:0] < y[30:0]) begin
         t = x; x = y; y = t;
         ex = int'(x[30:23]);
         ey = int'(y[30:23]);
      end
      d = ex - ey;
      if (d > 30) return x;
      mx = longint'({1'b1, x[22:0]}) << d;
      my = longint'({1'b1, y[22:0]});
      s = (x[31] ? -mx : mx) + (y[31] ? -my : my);
      if (s == 0) return 32'h0;
      neg = (s < 0);
      m = neg ? -s : s;
      p = 0;
      for (int i = 0; i < 63; i++) if (m[i]) p = i;
      if (p > 23) begin
         shift = p - 23;
         q = m >>> shift;
         rem = m - (q << shift);
         half = longint'(1) << (shift - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (longint'(1) << 24)) begin
            q = q >>> 1;
            shift++;
         end
         e = ey + shift;
      end else begin
         q = m << (23 - p);
         e = ey - (23 - p);
      end
      if (e >= 255) return {neg, 8'hFF, 23'h0};
      if (e <= 0) return {neg, 31'h0};
      return {neg, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp(input int base);
      int k, e;
      logic s;
      logic [22:0] f;
      k = int'($urandom_range(0, 19));
      s = 1'($urandom);
      f = 23'($urandom);
      if (k == 0) return {s, 8'hFF, f | 23'h1};
      if (k == 1) return {s, 8'hFF, 23'h0};
      if (k == 2) return {s, 31'h0};
      if (k == 3) return {s, 8'h00, f};
      if (base < 0)   e = int'($urandom_range(1, 254));
      else if (k < 8) e = base + int'($urandom_range(0, 60)) - 30;
      else            e = base + int'($urandom_range(0, 6)) - 3;
      if (e < 1)   e = 1;
      if (e > 254) e = 254;
      return {s, 8'(e), f};
   endfunction

   // Optional noise drives load and result_ack while the FSM is busy.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit noisy,
                        output logic [31:0] r);
      int lat;
      Number1 = x;
      Number2 = y;
      load = 1'b1;
      @(posedge clk); #1;
      load = noisy;
      result_ack = noisy;
      if (noisy) begin
         Number1 = $urandom;
         Number2 = $urandom;
      end
      lat = 0;
      while (!result_ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 4) begin
            load = 1'b0;
            result_ack = 1'b0;
         end
      end
      load = 1'b0;
      result_ack = 1'b0;
      check("latency", 32'(lat), 32'd5);
      r = Result;
   endtask

   task automatic ack_op();
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
      check("ack_clears_ready", {31'h0, result_ready}, 32'h0);
   endtask

   task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] expv);
      logic [31:0] r;
      do_op(x, y, 1'b0, r);
      check(tag, r, expv);
      ack_op();
   endtask

   initial begin
      logic [31:0] r, x, y;
      int mode, seen;
      reset = 1'b1;
      load = 1'b0;
      result_ack = 1'b0;
      Number1 = 32'h0;
      Number2 = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {31'h0, result_ready}, 32'h0);
      check("reset_result", Result, 32'h0);

      load = 1'b1;
      Number1 = 32'h4144CCCD;
      Number2 = 32'h41658520;
      repeat (8) @(posedge clk);
      #1;
      check("reset_load_ready", {31'h0, result_ready}, 32'h0);
      check("reset_load_result", Result, 32'h0);
      load = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      do_op(32'h4144CCCD, 32'h41658520, 1'b0, r);
      check("basic_add", r, 32'h41D528F6);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_ready", {31'h0, result_ready}, 32'h1);
         check("hold_result", Result, 32'h41D528F6);
      end
      ack_op();

      directed("sub_norm",     32'h3F800000, 32'hBF000000, 32'h3F000000);
      directed("cancel",       32'h40400000, 32'hC0400000, 32'h00000000);
      directed("tie_even",     32'h4B800000, 32'h3F800000, 32'h4B800000);
      directed("round_up",     32'h4B800000, 32'h40000000, 32'h4B800001);
      directed("inf_minus_inf",32'h7F800000, 32'hFF800000, 32'h7FC00000);
      directed("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      directed("nan_in",       32'h7FC12345, 32'h3F800000, 32'h7FC00000);
      directed("inf_finite",   32'hFF800000, 32'h42000000, 32'hFF800000);
      directed("pz_nz",        32'h00000000, 32'h80000000, 32'h00000000);
      directed("nz_nz",        32'h80000000, 32'h80000000, 32'h80000000);
      directed("zero_x",       32'h00000000, 32'hC1200000, 32'hC1200000);
      directed("denorm_flush", 32'h00000001, 32'h3F800000, 32'h3F800000);
      directed("underflow",    32'h00800001, 32'h80800000, 32'h00000000);
      directed("far_sticky",   32'h3F800000, 32'hB3000001, 32'h3F7FFFFF);

      Number1 = 32'h3F800000;
      Number2 = 32'h40000000;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_result", Result, 32'h0);
      check("abort_ready", {31'h0, result_ready}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (result_ready) seen++;
      end
      check("abort_no_ready", 32'(seen), 32'd0);
      directed("after_abort",  32'h3F800000, 32'h40000000, 32'h40400000);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) x = rand_fp(($urandom_range(0, 1) == 0) ? 252 : 3);
         else                           x = rand_fp(-1);
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       y = rand_fp(-1);
            1, 3:    y = rand_fp(int'(x[30:23]));
            default: y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 3))};
         endcase
         do_op(x, y, ($urandom_range(0, 3) == 0), r);
         check($sformatf("rand %h+%h", x, y), r, ref_add(x, y));
         ack_op();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- Multi-cycle IEEE-754 binary32 (single-precision) floating-point adder with a load/ready/ack handshake.
- Operands are captured on `load`, processed by an internal FSM, and held on `Result` with `result_ready` until the consumer acknowledges.
- Leaf arithmetic block, instantiated by the higher-level FP datapath.

Parameters:
- None. Format is fixed binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears the FSM and outputs while high.
- load  input  1  start request; sampled only in IDLE.
- Number1  input  32  operand A (binary32).
- Number2  input  32  operand B (binary32).
- result_ack  input  1  consumer has taken Result; sampled only in DONE.
- Result  output  32  A+B (binary32), registered.
- result_ready  output  1  Result valid; registered, high only in DONE.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE, Result=32'h0, result_ready=0, internal registers cleared.
  - Load and ack are ignored while reset is high.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE. Each state lasts one cycle except IDLE and DONE.
- IDLE:
  - On a rising edge with load=1, latch Number1/Number2 and go to UNPACK. Otherwise stay.
  - load=0 keeps the block idle.
- UNPACK:
  - Split sign, exponent and fraction; prepend the hidden 1 for normal numbers.
  - Classify each operand as zero, denormal, normal, inf or NaN.
  - Denormal inputs are flushed to signed zero.
- ALIGN:
  - Swap so the larger magnitude is operand A.
  - Right-shift B's significand by the exponent difference, keeping guard, round and sticky bits.
  - A shift of 27 or more leaves only sticky.
- ADD: add significands if signs are equal, else subtract the smaller from the larger. Result sign is the sign of the larger-magnitude operand.
- NORM:
  - On carry-out, shift right 1 (OR the dropped bit into sticky) and increment the exponent.
  - Otherwise left-shift by the leading-zero count and decrement the exponent, as a single-cycle barrel shift.
- ROUND:
  - Round to nearest, ties to even, using guard/round/sticky.
  - A mantissa overflow from rounding renormalises and increments the exponent.
- DONE:
  - Result holds the packed value and result_ready=1.
  - A rising edge with result_ack=1 returns to IDLE and clears result_ready.
  - Result keeps its value until the next operation completes.
- Latency and throughput:
  - result_ready rises exactly 6 edges after the edge that sampled load: that edge plus 5 processing edges.
  - At most one operation in flight. load outside IDLE is ignored, and ack outside DONE is ignored.
- Special cases, resolved in UNPACK and bypassing to DONE with the same 6-edge latency:
  - Any NaN -> 32'h7FC00000.
  - inf + -inf -> 32'h7FC00000.
  - inf + finite -> that inf.
  - zero + x -> x.
  - +0 + -0 -> +0; -0 + -0 -> -0.
- Exact cancellation (x + -x) -> +0.
- Overflow: exponent reaching 255 -> signed infinity.
- Underflow: biased exponent at or below 0 after normalisation -> signed zero (flush-to-zero).
- Reset asserted mid-operation aborts immediately. No partial result is presented.

Decomposition:
- Shared package fp32_pkg holds:
  - constants: EXP_BIAS=127, EXP_W=8, FRAC_W=23, QNAN=32'h7FC00000, POS_INF, NEG_INF;
  - the FSM state enum;
  - an operand-class enum (ZERO, NORMAL, INF, NAN).
- One natural sub-module: fp_lzc, a combinational 28-bit leading-zero counter used by NORM.

Test Plan:
- Basic add: 32'h4144CCCD (12.3) + 32'h41658520 (14.345), load pulsed -> 6 edges later result_ready=1, Result=32'h41D528F6 (26.645).
- Handshake: hold result_ack=0 for 10 cycles -> result_ready and Result stay stable. Pulse ack -> result_ready=0 next edge, FSM back in IDLE. A second load is accepted afterwards.
- Subtraction/normalisation:
  - 32'h3F800000 (1.0) + 32'hBF000000 (-0.5) -> 32'h3F000000.
  - 32'h40400000 + 32'hC0400000 -> 32'h00000000.
- Rounding: 32'h4B800000 (2^24) + 32'h3F800000 (1.0) -> tie, rounds to even -> 32'h4B800000. Adding 32'h40000000 (2.0) instead -> 32'h4B800001.
- Specials:
  - 32'h7F800000 + 32'hFF800000 -> 32'h7FC00000.
  - 32'h7F7FFFFF + 32'h7F7FFFFF -> 32'h7F800000.
  - NaN input -> 32'h7FC00000.
- Reset: hold reset=1 with load=1 -> result_ready stays 0, Result=0. Assert reset mid-computation -> outputs clear immediately and no result_ready pulse occurs.
